// File: rtl/cycle_timer_capture.sv
// Purpose : timestamps START/STOP pulses against the shared COUNT bus; keeps last/max/min elapsed and a run count behind a word read port.
// Latency : STOP -> RESULT_VALID/LAST_CYCLES is 2 cycles; RD_ADDR -> RD_DATA is 1 cycle.
// Backpressure: none; a pulse is acted on in the cycle it arrives, and a START in the DONE cycle chains the next run.
module cycle_timer_capture #(
   parameter int COUNTER_LENGTH = 128,
   parameter int WORD_WIDTH     = 32
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic [COUNTER_LENGTH-1:0] COUNT,
   input  logic                      START,
   input  logic                      STOP,
   input  logic                      CLEAR,
   input  logic [3:0]                RD_ADDR,
   output logic [WORD_WIDTH-1:0]     RD_DATA,
   output logic [COUNTER_LENGTH-1:0] LAST_CYCLES,
   output logic                      RESULT_VALID,
   output logic                      BUSY
);

   // A group of four read words can hold the widest legal counter; narrower
   // counters are zero-extended so out-of-range word indices read 0.
   localparam int PAD_W = 4 * WORD_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [COUNTER_LENGTH-1:0] r_start_ts;
   logic [COUNTER_LENGTH-1:0] r_stop_ts;
   logic [COUNTER_LENGTH-1:0] r_last;
   logic [COUNTER_LENGTH-1:0] r_max;
   logic [COUNTER_LENGTH-1:0] r_min;
   logic [WORD_WIDTH-1:0]     r_runs;
   logic                      r_stray_stop;
   logic                      r_restart_err;
   logic                      r_result_valid;
   logic [WORD_WIDTH-1:0]     r_rd_data;
   logic [COUNTER_LENGTH-1:0] w_elapsed;
   logic [PAD_W-1:0]          w_sel_pad;
   logic [WORD_WIDTH-1:0]     w_rd_word;
   int                        w_word_base;

   // Modular subtraction makes the elapsed count correct across a COUNT wrap.
   assign w_elapsed    = r_stop_ts - r_start_ts;
   assign BUSY         = (r_state != S_IDLE);
   assign LAST_CYCLES  = r_last;
   assign RESULT_VALID = r_result_valid;
   assign RD_DATA      = r_rd_data;

   // State register; RESET and CLEAR both abandon any run in progress.
   always_ff @(posedge CLOCK) begin
      if (RESET || CLEAR) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: DONE lasts exactly one cycle and may chain straight into a new run.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (START) w_next_state = S_RUNNING;
         S_RUNNING: if (STOP)  w_next_state = S_DONE;
         S_DONE:    w_next_state = START ? S_RUNNING : S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Timestamp capture, statistics update on the closing edge of DONE, sticky error flags.
   always_ff @(posedge CLOCK) begin
      if (RESET || CLEAR) begin
         r_start_ts     <= '0;
         r_stop_ts      <= '0;
         r_last         <= '0;
         r_max          <= '0;
         r_min          <= '1;
         r_runs         <= '0;
         r_stray_stop   <= 1'b0;
         r_restart_err  <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // START wins over a simultaneous STOP, which is dropped silently.
               if (START) begin
                  r_start_ts <= COUNT;
               end else if (STOP) begin
                  r_stray_stop <= 1'b1;
               end
            end
            S_RUNNING: begin
               // STOP wins over a simultaneous START; a lone START restarts timing.
               if (STOP) begin
                  r_stop_ts <= COUNT;
               end else if (START) begin
                  r_start_ts    <= COUNT;
                  r_restart_err <= 1'b1;
               end
            end
            S_DONE: begin
               r_last         <= w_elapsed;
               r_result_valid <= 1'b1;
               if (w_elapsed > r_max) begin
                  r_max <= w_elapsed;
               end
               if (w_elapsed < r_min) begin
                  r_min <= w_elapsed;
               end
               if (r_runs != '1) begin
                  r_runs <= r_runs + 1'b1;
               end
               if (START) begin
                  r_start_ts <= COUNT;
               end
               if (STOP) begin
                  r_stray_stop <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Read mux: address bits [3:2] pick the group, [1:0] the little-endian word within it.
   always_comb begin
      w_sel_pad   = '0;
      w_rd_word   = '0;
      w_word_base = int'(RD_ADDR[1:0]) * WORD_WIDTH;
      case (RD_ADDR[3:2])
         2'd0:    w_sel_pad[COUNTER_LENGTH-1:0] = r_last;
         2'd1:    w_sel_pad[COUNTER_LENGTH-1:0] = r_max;
         2'd2:    w_sel_pad[COUNTER_LENGTH-1:0] = r_min;
         default: w_sel_pad = '0;
      endcase
      if (RD_ADDR[3:2] != 2'd3) begin
         w_rd_word = w_sel_pad[w_word_base +: WORD_WIDTH];
      end else begin
         case (RD_ADDR[1:0])
            2'd0:    w_rd_word = r_runs;
            2'd1:    w_rd_word = {{(WORD_WIDTH-3){1'b0}}, r_restart_err, r_stray_stop, BUSY};
            default: w_rd_word = '0;
         endcase
      end
   end

   // Registered read data; a same-edge statistics update shows up on the following read.
   always_ff @(posedge CLOCK) begin
      if (RESET || CLEAR) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_word;
      end
   end

endmodule

// File: tb/tb_cycle_timer_capture.sv
// Purpose : directed and randomized runs of cycle_timer_capture against an operation-level model.
// Latency : inputs driven 1ns after each rising edge; outputs sampled at the same point.
// Backpressure: not applicable; the bench drives pulses freely.
module tb_cycle_timer_capture;

   localparam int CL = 128;
   localparam int WW = 32;
   typedef logic [CL-1:0] wide_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          start;
   logic          stop;
   logic [CL-1:0] count;
   logic [3:0]    rd_addr;
   logic [WW-1:0] rd_data;
   logic [CL-1:0] last_cycles;
   logic          result_valid;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   // Operation-level reference state.
   logic [CL-1:0] m_last;
   logic [CL-1:0] m_max;
   logic [CL-1:0] m_min;
   logic [WW-1:0] m_runs;
   logic          m_stray;
   logic          m_restart;
   logic [CL-1:0] cnt_start;
   logic          pend;
   logic [CL-1:0] pend_exp;

   always #5 clk = ~clk;

   cycle_timer_capture #(.COUNTER_LENGTH(CL), .WORD_WIDTH(WW)) dut (
      .CLOCK        (clk),
      .RESET        (rst),
      .COUNT        (count),
      .START        (start),
      .STOP         (stop),
      .CLEAR        (clr),
      .RD_ADDR      (rd_addr),
      .RD_DATA      (rd_data),
      .LAST_CYCLES  (last_cycles),
      .RESULT_VALID (result_valid),
      .BUSY         (busy)
   );

   // One clock: the free-running counter advances once per cycle.
   task automatic step();
      @(posedge clk);
      #1;
      count = count + wide_t'(1);
   endtask

   task automatic chk(input string tag, input wide_t obs, input wide_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_last    = '0;
      m_max     = '0;
      m_min     = '1;
      m_runs    = '0;
      m_stray   = 1'b0;
      m_restart = 1'b0;
      pend      = 1'b0;
   endtask

   task automatic m_result(input wide_t e);
      m_last = e;
      if (e > m_max) m_max = e;
      if (e < m_min) m_min = e;
      if (m_runs != '1) m_runs = m_runs + 32'd1;
   endtask

   // Expected read word, assuming the read is issued while idle.
   function automatic logic [WW-1:0] exp_word(input int a);
      wide_t v;
      case (a / 4)
         0:       v = m_last;
         1:       v = m_max;
         2:       v = m_min;
         default: v = '0;
      endcase
      if (a < 12) return v[(a % 4) * WW +: WW];
      if (a == 12) return m_runs;
      if (a == 13) return {29'd0, m_restart, m_stray, 1'b0};
      return '0;
   endfunction

   task automatic rd(input int a);
      rd_addr = 4'(a);
      step();
      chk($sformatf("rd_addr%0d", a), wide_t'(rd_data), wide_t'(exp_word(a)));
   endtask

   task automatic clear_pulse();
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_reset();
      chk("clear_busy", wide_t'(busy), wide_t'(0));
   endtask

   // One operation: START sampled now, STOP sampled len cycles later.
   // roff>0 re-issues START roff cycles in; chain asserts the next START in the DONE cycle.
   task automatic run_op(input int len, input int roff, input bit chain,
                         input bit both_at_stop, input bit both_at_start,
                         input bit stop_in_done, input wide_t jump);
      wide_t e;
      start     = 1'b1;
      stop      = both_at_start;
      cnt_start = count;
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (pend) begin
         chk("chain_rv", wide_t'(result_valid), wide_t'(1));
         chk("chain_last", last_cycles, pend_exp);
         pend = 1'b0;
      end else begin
         chk("start_rv", wide_t'(result_valid), wide_t'(0));
      end
      chk("start_busy", wide_t'(busy), wide_t'(1));
      for (int i = 1; i < len; i++) begin
         if (jump != '0 && i == len / 2) count = count + jump;
         if (i == roff) begin
            start     = 1'b1;
            cnt_start = count;
            m_restart = 1'b1;
         end
         step();
         start = 1'b0;
      end
      stop  = 1'b1;
      start = both_at_stop;
      e     = count - cnt_start;
      step();
      stop  = 1'b0;
      start = 1'b0;
      chk("done_rv", wide_t'(result_valid), wide_t'(0));
      chk("done_busy", wide_t'(busy), wide_t'(1));
      m_result(e);
      if (chain) begin
         pend     = 1'b1;
         pend_exp = e;
      end else begin
         if (stop_in_done) begin
            stop    = 1'b1;
            m_stray = 1'b1;
         end
         step();
         stop = 1'b0;
         chk("res_rv", wide_t'(result_valid), wide_t'(1));
         chk("res_last", last_cycles, e);
         chk("res_busy", wide_t'(busy), wide_t'(0));
         step();
         chk("res_rv_drop", wide_t'(result_valid), wide_t'(0));
      end
   endtask

   initial begin
      int    len;
      int    roff;
      bit    chain;
      bit    prev_chain;
      bit    sid;
      wide_t jmp;

      rst = 1'b1; clr = 1'b0; start = 1'b0; stop = 1'b0;
      count = '0; rd_addr = '0;
      m_reset();
      step();
      step();
      rst = 1'b0;

      // Reset values
      chk("rst_busy", wide_t'(busy), wide_t'(0));
      chk("rst_rv", wide_t'(result_valid), wide_t'(0));
      chk("rst_rd", wide_t'(rd_data), wide_t'(0));
      chk("rst_last", last_cycles, wide_t'(0));
      for (int a = 0; a < 14; a++) rd(a);

      // Basic run: START at COUNT=100, STOP at COUNT=1100
      count = wide_t'(100);
      run_op(1000, 0, 0, 0, 0, 0, '0);
      chk("basic_last", last_cycles, wide_t'(1000));
      rd(0); rd(4); rd(5); rd(8); rd(12);

      // Wrap: START at 2^128-5, STOP at 5
      count = '1 - wide_t'(4);
      run_op(10, 0, 0, 0, 0, 0, '0);
      chk("wrap_last", last_cycles, wide_t'(10));
      rd(8);

      // Stats over three runs, first two chained through the DONE cycle
      clear_pulse();
      run_op(50, 0, 1, 0, 0, 0, '0);
      run_op(20, 0, 1, 0, 0, 0, '0);
      run_op(80, 0, 0, 0, 0, 0, '0);
      rd(0); rd(4); rd(8); rd(12); rd(13);

      // STOP in IDLE: sticky stray flag, no result
      clear_pulse();
      stop = 1'b1;
      step();
      stop = 1'b0;
      m_stray = 1'b1;
      chk("stray_rv", wide_t'(result_valid), wide_t'(0));
      step();
      chk("stray_rv2", wide_t'(result_valid), wide_t'(0));
      rd(13);

      // Restart at +30, STOP at +100 -> 70
      run_op(100, 30, 0, 0, 0, 0, '0);
      chk("restart_last", last_cycles, wide_t'(70));
      rd(13);

      // START+STOP together in RUNNING acts as STOP; in IDLE acts as START
      clear_pulse();
      run_op(40, 0, 0, 1, 0, 0, '0);
      run_op(25, 0, 0, 0, 1, 0, '0);
      rd(0); rd(13);

      // Randomized runs
      clear_pulse();
      prev_chain = 1'b0;
      for (int it = 0; it < 24; it++) begin
         if (!prev_chain && ($urandom % 4) == 0)
            count = {$urandom, $urandom, $urandom, $urandom};
         len   = int'($urandom_range(2, 60));
         roff  = (($urandom % 4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
         chain = (it != 23) && (($urandom % 3) == 0);
         jmp   = (($urandom % 4) == 0) ? {$urandom, $urandom, $urandom, $urandom} : '0;
         sid   = !chain && (($urandom % 4) == 0);
         run_op(len, roff, chain, 0, 0, sid, jmp);
         prev_chain = chain;
      end
      for (int a = 0; a < 16; a++) rd(a);

      // CLEAR mid-run abandons the run and wipes the statistics
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_reset();
      chk("abort_busy", wide_t'(busy), wide_t'(0));
      chk("abort_rv", wide_t'(result_valid), wide_t'(0));
      step();
      chk("abort_rv2", wide_t'(result_valid), wide_t'(0));
      for (int a = 0; a < 14; a++) rd(a);

      // Wide elapsed value exercises upper read words
      run_op(30, 0, 0, 0, 0, 0, wide_t'(128'h0000_00A5_1234_5678_9ABC_DEF0_0000_0000));
      rd(1); rd(2); rd(3); rd(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
